video_timing_gen: RTL and testbench

// Parametrised raster timing generator for the G10k video pipe: single-clock design with a pixel-enable divider.

---
 rtl/video_timing_gen_pkg.sv | 28 ++
 rtl/video_timing_gen_pix_en_div.sv | 32 +++
 rtl/video_timing_gen.sv | 143 ++++++++++++++
 tb/tb_video_timing_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_gen_pkg.sv
// Shared raster constants for the G10k video pipe: 640x480@60 defaults,
// line/frame length helpers and sync polarity encodings.
package video_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_pix_en_div.sv
// Pixel-enable divider: one-clk pix_en pulse every CLK_DIV clocks,
// registered so it is low throughout reset.
module pix_en_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic [DW-1:0] div_nxt;

  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + DW'(1);
  end

  // pix_en is computed from the next divider value so it is high in the clk where div==CLK_DIV-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      div    <= div_nxt;
      pix_en <= (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, sync/de decode, double-buffered
// scroll offsets and frame/line interrupts, all on a single clock.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned H_FP         = DEF_H_FP,
  parameter int unsigned H_SYNC       = DEF_H_SYNC,
  parameter int unsigned H_BP         = DEF_H_BP,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned V_FP         = DEF_V_FP,
  parameter int unsigned V_SYNC       = DEF_V_SYNC,
  parameter int unsigned V_BP         = DEF_V_BP,
  parameter logic        HS_POL       = SYNC_ACTIVE_LOW,
  parameter logic        VS_POL       = SYNC_ACTIVE_LOW,
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned XW           = 10,
  parameter int unsigned YW           = 10,
  parameter int unsigned SX_W         = 7,
  parameter int unsigned SY_W         = 5,
  parameter int unsigned SCROLL_SHIFT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SX_W-1:0] scroll_x,
  input  logic [SY_W-1:0] scroll_y,
  input  logic            scroll_wr,
  input  logic [YW-1:0]   line_cmp,
  output logic            pix_en,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic [XW-1:0]   cx,
  output logic [YW-1:0]   cy,
  output logic [XW-1:0]   sx,
  output logic [YW-1:0]   sy,
  output logic            frame_irq,
  output logic            line_irq
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);

  logic [XW-1:0]   hcnt;
  logic [YW-1:0]   vcnt;
  logic [SX_W-1:0] pend_x, shadow_x;
  logic [SY_W-1:0] pend_y, shadow_y;
  logic            pend_flag;

  logic            frame_wrap;
  logic            line_hit;
  logic [31:0]     h_w, v_w;
  logic [XW-1:0]   x_off;
  logic [YW-1:0]   y_off;

  pix_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  always_comb begin
    h_w        = 32'(hcnt);
    v_w        = 32'(vcnt);
    frame_wrap = pix_en && (hcnt == H_LAST) && (vcnt == V_LAST);
    line_hit   = pix_en && (hcnt == H_ACT_LAST) && (vcnt == line_cmp);
    x_off      = XW'(shadow_x) << SCROLL_SHIFT;
    y_off      = YW'(shadow_y) << SCROLL_SHIFT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + YW'(1);
      end else begin
        hcnt <= hcnt + XW'(1);
      end
    end
  end

  // The shadow loads the pending value held before this edge; a write landing on
  // the wrap clk therefore stays pending (flag re-set) for the following frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_x    <= '0;
      pend_y    <= '0;
      shadow_x  <= '0;
      shadow_y  <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (frame_wrap && pend_flag) begin
        shadow_x <= pend_x;
        shadow_y <= pend_y;
      end
      if (scroll_wr) begin
        pend_x    <= scroll_x;
        pend_y    <= scroll_y;
        pend_flag <= 1'b1;
      end else if (frame_wrap) begin
        pend_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync     <= ~HS_POL;
      vsync     <= ~VS_POL;
      de        <= 1'b0;
      cx        <= '0;
      cy        <= '0;
      sx        <= '0;
      sy        <= '0;
      frame_irq <= 1'b0;
      line_irq  <= 1'b0;
    end else begin
      hsync     <= ((h_w >= HS_BEG) && (h_w < HS_END)) ? HS_POL : ~HS_POL;
      vsync     <= ((v_w >= VS_BEG) && (v_w < VS_END)) ? VS_POL : ~VS_POL;
      de        <= (h_w < H_ACTIVE) && (v_w < V_ACTIVE);
      cx        <= hcnt;
      cy        <= vcnt;
      sx        <= hcnt + x_off;
      sy        <= vcnt + y_off;
      frame_irq <= frame_wrap;
      line_irq  <= line_hit;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced 16x10 raster (CLK_DIV=2)
// plus a CLK_DIV=1, active-high-hsync variant sharing clk and reset.
module tb_video_timing_gen;

  logic       clk;
  logic       rst;
  logic [2:0] scroll_x;
  logic [1:0] scroll_y;
  logic       scroll_wr;
  logic [3:0] line_cmp;

  logic       pix_en, hsync, vsync, de, frame_irq, line_irq;
  logic [3:0] cx, cy, sx, sy;
  logic       pix_en1, hsync1, vsync1, de1, frame_irq1, line_irq1;
  logic [3:0] cx1, cy1, sx1, sy1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int n_pix, n_hs, hs_first, n_vs, vs_first, n_de, n_li, li_at, n_fi, n_sxdiff;
  int n_pix1_low, n_hs1, hs1_first;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2),
    .XW(4), .YW(4), .SX_W(3), .SY_W(2), .SCROLL_SHIFT(1)
  ) dut (
    .clk(clk), .rst(rst), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .scroll_wr(scroll_wr), .line_cmp(line_cmp), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .de(de), .cx(cx), .cy(cy), .sx(sx), .sy(sy),
    .frame_irq(frame_irq), .line_irq(line_irq)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(1),
    .XW(4), .YW(4), .SX_W(3), .SY_W(2), .SCROLL_SHIFT(1)
  ) dut1 (
    .clk(clk), .rst(rst), .scroll_x(3'd0), .scroll_y(2'd0),
    .scroll_wr(1'b0), .line_cmp(4'd0), .pix_en(pix_en1),
    .hsync(hsync1), .vsync(vsync1), .de(de1), .cx(cx1), .cy(cy1), .sx(sx1), .sy(sy1),
    .frame_irq(frame_irq1), .line_irq(line_irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b0; scroll_wr = 1'b0; scroll_x = '0; scroll_y = '0; line_cmp = 4'd2;
    n_pix = 0; n_hs = 0; hs_first = 0; n_vs = 0; vs_first = 0; n_de = 0;
    n_li = 0; li_at = 0; n_fi = 0; n_sxdiff = 0; n_pix1_low = 0; n_hs1 = 0; hs1_first = 0;

    repeat (5) @(posedge clk);
    #1;
    chk("rst_pix_en", pix_en, 1'b0);
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_de", de, 1'b0);
    chk("rst_cx", cx, 4'd0);
    chk("rst_cy", cy, 4'd0);
    chk("rst_sx", sx, 4'd0);
    chk("rst_sy", sy, 4'd0);
    chk("rst_frame_irq", frame_irq, 1'b0);
    chk("rst_line_irq", line_irq, 1'b0);
    chk("rst_hsync_hipol", hsync1, 1'b0);
    chk("rst_pix_en_div1", pix_en1, 1'b0);

    rst = 1'b1;
    cyc = 0;

    // frame 0: k = 1..320
    for (int i = 0; i < 320; i++) begin
      adv();
      if (pix_en) n_pix++;
      if (!hsync) begin n_hs++; if (hs_first == 0) hs_first = cyc; end
      if (!vsync) begin n_vs++; if (vs_first == 0) vs_first = cyc; end
      if (de) n_de++;
      if (line_irq) begin n_li++; li_at = cyc; end
      if (frame_irq) n_fi++;
      if (sx != cx) n_sxdiff++;
      if (!pix_en1) n_pix1_low++;
      if (cyc <= 32 && hsync1) begin n_hs1++; if (hs1_first == 0) hs1_first = cyc; end
      if (cyc == 1) begin
        chk("div_first_pulse", pix_en, 1'b1);
        chk("cx_first", cx, 4'd0);
        chk("de_first", de, 1'b1);
      end
      if (cyc == 2) begin
        chk("div_gap", pix_en, 1'b0);
        chk("div1_de", de1, 1'b1);
        chk("div1_vsync", vsync1, 1'b1);
        chk("div1_cy", cy1, 4'd0);
        chk("div1_sx", sx1, 4'd0);
        chk("div1_sy", sy1, 4'd0);
      end
      if (cyc == 9) chk("div1_line_irq", line_irq1, 1'b1);
      if (cyc == 12) chk("div1_cx12", cx1, 4'd10);
      if (cyc == 160) chk("div1_frame_irq_pre", frame_irq1, 1'b0);
      if (cyc == 161) chk("div1_frame_irq", frame_irq1, 1'b1);
      if (cyc == 162) chk("div1_frame_irq_post", frame_irq1, 1'b0);
      if (cyc == 319) chk("frame_irq_pre", frame_irq, 1'b0);
      if (cyc == 320) chk("frame_irq_wrap0", frame_irq, 1'b1);
      if (cyc == 100) begin scroll_x = 3'd5; scroll_y = 2'd3; scroll_wr = 1'b1; end
      if (cyc == 101) scroll_wr = 1'b0;
    end
    chk("pix_en_count", n_pix, 160);
    chk("hsync_low_clks", n_hs, 60);
    chk("hsync_first_low", hs_first, 21);
    chk("vsync_low_clks", n_vs, 64);
    chk("vsync_first_low", vs_first, 225);
    chk("de_high_clks", n_de, 96);
    chk("line_irq_count", n_li, 1);
    chk("line_irq_at", li_at, 80);
    chk("frame_irq_count0", n_fi, 1);
    chk("sx_unscrolled_f0", n_sxdiff, 0);
    chk("div1_pix_en_low", n_pix1_low, 0);
    chk("div1_hsync_high", n_hs1, 6);
    chk("div1_hsync_first", hs1_first, 12);

    // frame 1: k = 321..640
    n_fi = 0;
    for (int i = 0; i < 320; i++) begin
      adv();
      if (frame_irq) n_fi++;
      if (cyc == 321) begin
        chk("f1_cx", cx, 4'd0);
        chk("f1_cy", cy, 4'd0);
        chk("f1_sx", sx, 4'd10);
        chk("f1_sy", sy, 4'd6);
        chk("f1_frame_irq_width", frame_irq, 1'b0);
        chk("div1_frame_irq2", frame_irq1, 1'b1);
      end
      if (cyc == 333) begin
        chk("f1_cx6", cx, 4'd6);
        chk("f1_sx_wrap", sx, 4'd0);
      end
      if (cyc == 352) chk("f1_sx_cx15", sx, 4'd9);
      if (cyc == 400) begin scroll_x = 3'd1; scroll_wr = 1'b1; end
      if (cyc == 401) scroll_wr = 1'b0;
      if (cyc == 639) begin scroll_x = 3'd2; scroll_wr = 1'b1; end
      if (cyc == 640) begin
        chk("frame_irq_wrap1", frame_irq, 1'b1);
        scroll_wr = 1'b0;
        line_cmp  = 4'd12;
      end
    end
    chk("frame_irq_count1", n_fi, 1);

    // frame 2: k = 641..960, line_cmp beyond V_TOTAL
    n_li = 0;
    for (int i = 0; i < 320; i++) begin
      adv();
      if (line_irq) n_li++;
      if (cyc == 641) begin
        chk("f2_sx_off2", sx, 4'd2);
        chk("f2_sy", sy, 4'd6);
      end
      if (cyc == 960) chk("frame_irq_wrap2", frame_irq, 1'b1);
    end
    chk("line_irq_out_of_range", n_li, 0);
    adv();
    chk("f3_sx_off4", sx, 4'd4);
    chk("f3_sy", sy, 4'd6);

    // leave a write pending, then reset mid-frame
    repeat (19) adv();
    scroll_x = 3'd3; scroll_wr = 1'b1;
    adv();
    scroll_wr = 1'b0;
    repeat (4) adv();
    rst = 1'b0;
    #1;
    chk("mid_rst_cx", cx, 4'd0);
    chk("mid_rst_sx", sx, 4'd0);
    chk("mid_rst_hsync", hsync, 1'b1);
    chk("mid_rst_pix_en", pix_en, 1'b0);
    chk("mid_rst_de", de, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    n_fi = 0;
    for (int i = 0; i < 321; i++) begin
      adv();
      if (cyc < 320 && frame_irq) n_fi++;
      if (cyc == 320) chk("post_rst_wrap_irq", frame_irq, 1'b1);
      if (cyc == 321) begin
        chk("post_rst_cx", cx, 4'd0);
        chk("post_rst_pending_dropped", sx, 4'd0);
      end
    end
    chk("post_rst_no_restart_irq", n_fi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
